// File: rtl/ialm_log_encode_stage_if.sv
// Handshake bundle for the log-encode stage: operand input side and log-word output side.
interface ialm_log_encode_stage_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      log_a;
    logic [15:0]      log_b;
    logic             c0_o;
    logic             zero_o;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, log_a, log_b, c0_o, zero_o
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, log_a, log_b, c0_o, zero_o
    );
endinterface

// File: rtl/ialm_log_encode_stage.sv
// Two-stage log-domain encoder (LOD, then normalise/pack) for the approximate log multiplier.
// Optional `define IALM_COMP_EN drives c0_o as a one-LSB Mitchell compensation carry.
module ialm_log_encode_stage #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ialm_log_encode_stage_if.slave    bus
);

    function automatic logic [3:0] lod_f(input logic [WIDTH-1:0] x);
        logic [3:0] k;
        k = 4'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) begin
                k = 4'(i);
            end
        end
        return k;
    endfunction

    // Left-align the bits below the leading one into the 12-bit fraction field.
    function automatic logic [15:0] pack_f(input logic [WIDTH-1:0] x, input logic [3:0] k,
                                           input logic z);
        logic [WIDTH-1:0] sh;
        logic [11:0]      frac;
        sh   = x << (4'(WIDTH - 1) - k);
        frac = 12'(sh[WIDTH-2:0]) << (13 - WIDTH);
        return z ? 16'h0000 : {k, frac};
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [3:0]       s1_ka_q, s1_ka_d, s1_kb_q, s1_kb_d;
    logic             s1_za_q, s1_za_d, s1_zb_q, s1_zb_d;
    logic             s2_valid_q, s2_valid_d;
    logic [15:0]      log_a_q, log_a_d, log_b_q, log_b_d;
    logic             c0_q, c0_d, zero_q, zero_d;
    logic             s1_adv_s, s2_adv_s, s1_load_s;
    logic [15:0]      pack_a_s, pack_b_s;
    logic             zero_s, c0_s;

    // Pipeline advance conditions.
    always_comb begin
        s2_adv_s  = !s2_valid_q || bus.out_ready;
        s1_adv_s  = !s1_valid_q || s2_adv_s;
        s1_load_s = bus.in_valid && s1_adv_s;
    end

    // Stage 1 next state: capture operands, leading-one index and zero flags.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_ka_d    = s1_ka_q;
        s1_kb_d    = s1_kb_q;
        s1_za_d    = s1_za_q;
        s1_zb_d    = s1_zb_q;
        if (s1_adv_s) begin
            s1_valid_d = bus.in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s1_load_s) begin
            s1_a_d  = bus.in_a;
            s1_b_d  = bus.in_b;
            s1_ka_d = lod_f(bus.in_a);
            s1_kb_d = lod_f(bus.in_b);
            s1_za_d = (bus.in_a == {WIDTH{1'b0}});
            s1_zb_d = (bus.in_b == {WIDTH{1'b0}});
        end else begin
            s1_a_d  = s1_a_q;
            s1_b_d  = s1_b_q;
        end
    end

    // Stage 2 datapath: normalise, pack and derive the zero/carry flags.
    always_comb begin
        pack_a_s = pack_f(s1_a_q, s1_ka_q, s1_za_q);
        pack_b_s = pack_f(s1_b_q, s1_kb_q, s1_zb_q);
        zero_s   = s1_za_q || s1_zb_q;
`ifdef IALM_COMP_EN
        c0_s     = !zero_s && (pack_a_s[11:0] != 12'h000) && (pack_b_s[11:0] != 12'h000);
`else
        c0_s     = 1'b0;
`endif
    end

    // Stage 2 next state: outputs only move when the downstream side lets them.
    always_comb begin
        s2_valid_d = s2_valid_q;
        log_a_d    = log_a_q;
        log_b_d    = log_b_q;
        c0_d       = c0_q;
        zero_d     = zero_q;
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                log_a_d = pack_a_s;
                log_b_d = pack_b_s;
                c0_d    = c0_s;
                zero_d  = zero_s;
            end else begin
                log_a_d = log_a_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers; reset discards every in-flight entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= {WIDTH{1'b0}};
            s1_b_q     <= {WIDTH{1'b0}};
            s1_ka_q    <= 4'd0;
            s1_kb_q    <= 4'd0;
            s1_za_q    <= 1'b0;
            s1_zb_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            log_a_q    <= 16'h0000;
            log_b_q    <= 16'h0000;
            c0_q       <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_ka_q    <= s1_ka_d;
            s1_kb_q    <= s1_kb_d;
            s1_za_q    <= s1_za_d;
            s1_zb_q    <= s1_zb_d;
            s2_valid_q <= s2_valid_d;
            log_a_q    <= log_a_d;
            log_b_q    <= log_b_d;
            c0_q       <= c0_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.in_ready  = s1_adv_s;
    assign bus.out_valid = s2_valid_q;
    assign bus.log_a     = log_a_q;
    assign bus.log_b     = log_b_q;
    assign bus.c0_o      = c0_q;
    assign bus.zero_o    = zero_q;

endmodule
